// File: rtl/wb_daq_bus_reader_pkg.sv
// Descriptor layout shared with the ring writer, plus the reader sequencing states.
// No logic here; latency and backpressure are properties of the modules that import it.
// Offsets are relative to the descriptor base address.
package wb_daq_bus_reader_pkg;

    localparam logic [7:0] VECTOR_START_ADDRESS_OFFSET = 8'h00;
    localparam logic [7:0] VECTOR_END_ADDRESS_OFFSET   = 8'h04;
    localparam logic [7:0] VECTOR_WRITE_POINTER_OFFSET = 8'h08;
    localparam logic [7:0] VECTOR_READ_POINTER_OFFSET  = 8'h0C;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_RD_PTR    = 4'd1,
        S_WR_PTR    = 4'd2,
        S_START_PTR = 4'd3,
        S_END_PTR   = 4'd4,
        S_CHECK     = 4'd5,
        S_READ_DATA = 4'd6,
        S_PRESENT   = 4'd7,
        S_UPDATE    = 4'd8,
        S_WB_RD_PTR = 4'd9
    } rd_state_t;

endpackage

// File: rtl/wb_daq_bus_reader_wb_master_interface.sv
// Single classic Wishbone access engine with internal retry on rty.
// Latency: cyc/stb one edge after start, dropped on the ack/err/rty edge; done/err are combinational on that cycle.
// Backpressure: start is ignored while active (access in flight or retry pending).
module wb_master_interface #(
    parameter int dw        = 32,
    parameter int aw        = 32,
    parameter int MAX_RETRY = 4
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    input  logic          start,
    input  logic [aw-1:0] address,
    input  logic          write,
    input  logic [dw-1:0] data_wr,
    output logic [dw-1:0] data_rd,
    output logic          active,
    output logic          done,
    output logic          err,
    output logic [aw-1:0] wb_adr_o,
    output logic [dw-1:0] wb_dat_o,
    output logic [3:0]    wb_sel_o,
    output logic          wb_we_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic [2:0]    wb_cti_o,
    output logic [1:0]    wb_bte_o,
    input  logic [dw-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i,
    input  logic          wb_rty_i
);

    localparam int RW = $clog2(MAX_RETRY + 1);

    logic [RW-1:0] retry_cnt;
    logic          retry_pend;
    logic          retry_last;
    logic          rty_take;

    // err beats ack, ack beats rty
    assign retry_last = (retry_cnt == RW'(MAX_RETRY));
    assign rty_take   = wb_cyc_o && wb_rty_i && !wb_ack_i && !wb_err_i;
    assign done       = wb_cyc_o && wb_ack_i && !wb_err_i;
    assign err        = (wb_cyc_o && wb_err_i) || (rty_take && retry_last);
    assign data_rd    = wb_dat_i;
    assign active     = wb_cyc_o || retry_pend;
    assign wb_cti_o   = 3'b000;
    assign wb_bte_o   = 2'b00;

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            wb_sel_o   <= 4'h0;
            wb_we_o    <= 1'b0;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            retry_cnt  <= '0;
            retry_pend <= 1'b0;
        end else if (start && !active) begin
            wb_adr_o   <= address;
            wb_dat_o   <= data_wr;
            wb_we_o    <= write;
            wb_sel_o   <= 4'hF;
            wb_cyc_o   <= 1'b1;
            wb_stb_o   <= 1'b1;
            retry_cnt  <= '0;
        end else if (wb_cyc_o) begin
            if (wb_ack_i || wb_err_i || wb_rty_i) begin
                wb_cyc_o <= 1'b0;
                wb_stb_o <= 1'b0;
                wb_sel_o <= 4'h0;
                if (rty_take && !retry_last) begin
                    retry_cnt  <= retry_cnt + 1'b1;
                    retry_pend <= 1'b1;
                end else begin
                    wb_we_o <= 1'b0;
                end
            end
        end else if (retry_pend) begin
            // address, data and we are still held from the original issue
            wb_cyc_o   <= 1'b1;
            wb_stb_o   <= 1'b1;
            wb_sel_o   <= 4'hF;
            retry_pend <= 1'b0;
        end
    end

endmodule

// File: rtl/wb_daq_bus_reader.sv
// Wishbone DMA reader: pops one sample from the DAQ ring per start pulse and writes back the read pointer.
// Latency: 13 cycles start-to-idle for a non-empty pop with a 0-wait slave and sample_ready held high.
// Backpressure: holds sample_o/sample_valid in PRESENT until sample_ready; writeback only after the handshake.
module wb_daq_bus_reader
    import wb_daq_bus_reader_pkg::*;
#(
    parameter int dw        = 32,
    parameter int aw        = 32,
    parameter int MAX_RETRY = 4
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    output logic [aw-1:0] wb_adr_o,
    output logic [dw-1:0] wb_dat_o,
    output logic [3:0]    wb_sel_o,
    output logic          wb_we_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic [2:0]    wb_cti_o,
    output logic [1:0]    wb_bte_o,
    input  logic [dw-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i,
    input  logic          wb_rty_i,
    input  logic          start,
    input  logic [aw-1:0] address,
    output logic [dw-1:0] sample_o,
    output logic          sample_valid,
    input  logic          sample_ready,
    output logic          busy,
    output logic          empty,
    output logic          error
);

    rd_state_t     state, nxt_state, acc_next;
    logic [aw-1:0] base_q, rd_ptr, wr_ptr, start_ptr, end_ptr;
    logic [aw-1:0] inc_ptr, nxt_ptr, eng_adr, acc_adr;
    logic [dw-1:0] eng_wdat, eng_rdat;
    logic          eng_start, eng_we, eng_active, eng_done, eng_err;
    logic          acc, acc_we;

    assign inc_ptr  = rd_ptr + aw'(4);
    assign nxt_ptr  = (inc_ptr > end_ptr) ? start_ptr : inc_ptr;
    assign eng_wdat = dw'(nxt_ptr);
    assign busy     = (state != S_IDLE);

    wb_master_interface #(.dw(dw), .aw(aw), .MAX_RETRY(MAX_RETRY)) u_wbm (
        .wb_clk   (wb_clk),
        .wb_rst   (wb_rst),
        .start    (eng_start),
        .address  (eng_adr),
        .write    (eng_we),
        .data_wr  (eng_wdat),
        .data_rd  (eng_rdat),
        .active   (eng_active),
        .done     (eng_done),
        .err      (eng_err),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_sel_o (wb_sel_o),
        .wb_we_o  (wb_we_o),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_cti_o (wb_cti_o),
        .wb_bte_o (wb_bte_o),
        .wb_dat_i (wb_dat_i),
        .wb_ack_i (wb_ack_i),
        .wb_err_i (wb_err_i),
        .wb_rty_i (wb_rty_i)
    );

    always_ff @(posedge wb_clk) begin
        if (wb_rst) state <= S_IDLE;
        else        state <= nxt_state;
    end

    // Transitions out of IDLE/CHECK/UPDATE issue the next access on the same edge,
    // so the only idle bus cycle between accesses is the mandatory cyc drop.
    always_comb begin
        nxt_state = state;
        eng_start = 1'b0;
        eng_we    = 1'b0;
        eng_adr   = base_q + aw'(VECTOR_READ_POINTER_OFFSET);
        acc       = 1'b0;
        acc_we    = 1'b0;
        acc_adr   = base_q + aw'(VECTOR_READ_POINTER_OFFSET);
        acc_next  = S_IDLE;
        case (state)
            S_IDLE: begin
                if (start) begin
                    eng_start = 1'b1;
                    eng_adr   = address + aw'(VECTOR_READ_POINTER_OFFSET);
                    nxt_state = S_RD_PTR;
                end
            end
            S_RD_PTR: begin
                acc      = 1'b1;
                acc_next = S_WR_PTR;
            end
            S_WR_PTR: begin
                acc      = 1'b1;
                acc_adr  = base_q + aw'(VECTOR_WRITE_POINTER_OFFSET);
                acc_next = S_START_PTR;
            end
            S_START_PTR: begin
                acc      = 1'b1;
                acc_adr  = base_q + aw'(VECTOR_START_ADDRESS_OFFSET);
                acc_next = S_END_PTR;
            end
            S_END_PTR: begin
                acc      = 1'b1;
                acc_adr  = base_q + aw'(VECTOR_END_ADDRESS_OFFSET);
                acc_next = S_CHECK;
            end
            S_CHECK: begin
                if (rd_ptr == wr_ptr) begin
                    nxt_state = S_IDLE;
                end else begin
                    eng_start = 1'b1;
                    eng_adr   = rd_ptr;
                    nxt_state = S_READ_DATA;
                end
            end
            S_READ_DATA: begin
                acc      = 1'b1;
                acc_adr  = rd_ptr;
                acc_next = S_PRESENT;
            end
            S_PRESENT: begin
                if (sample_ready) nxt_state = S_UPDATE;
            end
            S_UPDATE: begin
                eng_start = 1'b1;
                eng_we    = 1'b1;
                nxt_state = S_WB_RD_PTR;
            end
            S_WB_RD_PTR: begin
                acc      = 1'b1;
                acc_we   = 1'b1;
                acc_next = S_IDLE;
            end
            default: nxt_state = S_IDLE;
        endcase
        if (acc) begin
            eng_adr = acc_adr;
            eng_we  = acc_we;
            if (eng_err)          nxt_state = S_IDLE;
            else if (eng_done)    nxt_state = acc_next;
            else if (!eng_active) eng_start = 1'b1;
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            base_q       <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            start_ptr    <= '0;
            end_ptr      <= '0;
            sample_o     <= '0;
            sample_valid <= 1'b0;
            empty        <= 1'b0;
            error        <= 1'b0;
        end else begin
            empty <= (state == S_CHECK) && (rd_ptr == wr_ptr);
            error <= eng_err;
            if (state == S_IDLE && start) base_q <= address;
            if (eng_done) begin
                case (state)
                    S_RD_PTR:    rd_ptr    <= aw'(eng_rdat);
                    S_WR_PTR:    wr_ptr    <= aw'(eng_rdat);
                    S_START_PTR: start_ptr <= aw'(eng_rdat);
                    S_END_PTR:   end_ptr   <= aw'(eng_rdat);
                    S_READ_DATA: begin
                        sample_o     <= eng_rdat;
                        sample_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
            if (state == S_PRESENT && sample_ready) sample_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_daq_bus_reader.sv
// Scoreboarded bench for wb_daq_bus_reader against a 0-wait Wishbone memory with err/rty injection.
module tb_wb_daq_bus_reader;

    logic        wb_clk = 1'b0;
    logic        wb_rst;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i, address, sample_o;
    logic [3:0]  wb_sel_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i, wb_rty_i;
    logic        start, sample_valid, sample_ready, busy, empty, error;

    always #5 wb_clk = ~wb_clk;

    wb_daq_bus_reader dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
        .start(start), .address(address), .sample_o(sample_o), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .busy(busy), .empty(empty), .error(error)
    );

    logic [31:0] mem [logic [31:0]];
    int          rty_left;
    logic [31:0] rty_addr, err_addr;
    logic        err_arm;
    int          n_cmp, n_bad, n_wr, n_empty, n_error, n_rp_rd, n_1004_rd;
    logic [31:0] exp_smp_q[$];
    logic [63:0] exp_wb_q[$];
    logic [63:0] mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // 0-wait slave: err injection, then rty injection, otherwise ack
    always_comb begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_rty_i = 1'b0;
        wb_dat_i = mem.exists(wb_adr_o) ? mem[wb_adr_o] : 32'h0;
        if (wb_cyc_o && wb_stb_o) begin
            if (err_arm && wb_adr_o == err_addr)         wb_err_i = 1'b1;
            else if (rty_left > 0 && wb_adr_o == rty_addr) wb_rty_i = 1'b1;
            else                                          wb_ack_i = 1'b1;
        end
    end

    always @(posedge wb_clk) begin
        if (wb_cyc_o && wb_stb_o) begin
            if (wb_rty_i) rty_left = rty_left - 1;
            if (wb_err_i) err_arm = 1'b0;
            if (!wb_we_o && wb_adr_o == 32'h10C) n_rp_rd++;
            if (!wb_we_o && wb_adr_o == 32'h1004) n_1004_rd++;
            if (wb_we_o && wb_ack_i) begin
                mem[wb_adr_o] = wb_dat_o;
                n_wr++;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a sample or a descriptor write
    always @(negedge wb_clk) begin
        if (sample_valid && sample_ready) begin
            if (exp_smp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_sample: got 0x%08h, expected no sample", sample_o);
            end else begin
                check("sample", sample_o, exp_smp_q.pop_front());
            end
        end
        if (wb_cyc_o && wb_stb_o && wb_we_o && wb_ack_i) begin
            if (exp_wb_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_write: got 0x%08h@0x%08h, expected no write", wb_dat_o, wb_adr_o);
            end else begin
                mon_e = exp_wb_q.pop_front();
                check("wb_adr", wb_adr_o, mon_e[63:32]);
                check("wb_dat", wb_dat_o, mon_e[31:0]);
            end
        end
        if (empty) n_empty++;
        if (error) n_error++;
    end

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic setup(input logic [31:0] rd, input logic [31:0] wr);
        mem[32'h10C] = rd;
        mem[32'h108] = wr;
        n_wr = 0; n_empty = 0; n_error = 0; n_rp_rd = 0; n_1004_rd = 0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 1;
        while (busy && cyc < 300) begin
            tick();
            cyc++;
        end
        if (busy) begin
            n_cmp++; n_bad++;
            $display("FAIL idle_timeout: got busy=1 after %0d cycles, expected idle", cyc);
        end
    endtask

    task automatic pop_run(output int cyc);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(cyc);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!sample_valid && n < 100) begin
            tick();
            n++;
        end
        check("valid_seen", {31'd0, sample_valid}, 32'd1);
    endtask

    task automatic drained(input string tag);
        check({tag, "_smp_left"}, exp_smp_q.size(), 32'd0);
        check({tag, "_wb_left"}, exp_wb_q.size(), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [31:0] held;
        logic stable;
        wb_rst = 1'b1; start = 1'b0; address = 32'h100; sample_ready = 1'b1;
        rty_left = 0; rty_addr = 32'h10C; err_arm = 1'b0; err_addr = 32'h0;
        n_cmp = 0; n_bad = 0;
        mem[32'h100] = 32'h1000;
        mem[32'h104] = 32'h100C;
        mem[32'h1000] = 32'hCAFE0001;
        mem[32'h1004] = 32'hCAFE0002;
        mem[32'h1008] = 32'hCAFE0003;
        mem[32'h100C] = 32'hCAFE0004;
        setup(32'h1000, 32'h1008);
        repeat (3) tick();
        check("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        check("rst_stb", {31'd0, wb_stb_o}, 32'd0);
        check("rst_sel", {28'd0, wb_sel_o}, 32'd0);
        check("rst_adr", wb_adr_o, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, sample_valid}, 32'd0);
        check("rst_flags", {30'd0, empty, error}, 32'd0);
        wb_rst = 1'b0;
        tick();

        // non-empty pop, zero-wait handshake
        setup(32'h1000, 32'h1008);
        exp_smp_q.push_back(32'hCAFE0001);
        exp_wb_q.push_back({32'h10C, 32'h1004});
        pop_run(lat);
        check("pop_latency_le14", {31'd0, lat <= 14}, 32'd1);
        check("pop_rdptr_mem", mem[32'h10C], 32'h1004);
        drained("pop");

        // wrap past end back to start
        setup(32'h100C, 32'h1000);
        exp_smp_q.push_back(32'hCAFE0004);
        exp_wb_q.push_back({32'h10C, 32'h1000});
        pop_run(lat);
        check("wrap_rdptr_mem", mem[32'h10C], 32'h1000);
        drained("wrap");

        // empty ring
        setup(32'h1004, 32'h1004);
        pop_run(lat);
        tick();
        check("empty_pulses", n_empty, 32'd1);
        check("empty_no_data_rd", n_1004_rd, 32'd0);
        check("empty_no_write", n_wr, 32'd0);
        drained("empty");

        // backpressure: ready low for 10 cycles after valid
        setup(32'h1004, 32'h1008);
        sample_ready = 1'b0;
        exp_smp_q.push_back(32'hCAFE0002);
        exp_wb_q.push_back({32'h10C, 32'h1008});
        start = 1'b1; tick(); start = 1'b0;
        wait_valid();
        held = sample_o;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!sample_valid || sample_o !== held || !busy) stable = 1'b0;
        end
        check("bp_held", {31'd0, stable}, 32'd1);
        check("bp_sample", held, 32'hCAFE0002);
        check("bp_no_early_write", n_wr, 32'd0);
        sample_ready = 1'b1;
        wait_idle(lat);
        check("bp_write_after", n_wr, 32'd1);
        drained("bp");

        // err on the data read
        setup(32'h1000, 32'h1008);
        err_addr = 32'h1000; err_arm = 1'b1;
        pop_run(lat);
        tick();
        check("err_pulse", n_error, 32'd1);
        check("err_no_write", n_wr, 32'd0);
        check("err_rdptr_mem", mem[32'h10C], 32'h1000);
        drained("err");

        // two retries on the read-pointer fetch
        setup(32'h1000, 32'h1008);
        rty_left = 2;
        exp_smp_q.push_back(32'hCAFE0001);
        exp_wb_q.push_back({32'h10C, 32'h1004});
        pop_run(lat);
        check("rty2_reissues", n_rp_rd, 32'd3);
        check("rty2_no_error", n_error, 32'd0);
        drained("rty2");

        // five retries exhaust the limit
        setup(32'h1000, 32'h1008);
        rty_left = 5;
        pop_run(lat);
        tick();
        check("rty5_error", n_error, 32'd1);
        check("rty5_attempts", n_rp_rd, 32'd5);
        check("rty5_no_write", n_wr, 32'd0);
        rty_left = 0;
        drained("rty5");

        // reset while presenting
        setup(32'h1000, 32'h1008);
        sample_ready = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        wait_valid();
        wb_rst = 1'b1;
        tick();
        check("rst_mid_valid", {31'd0, sample_valid}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_cyc", {31'd0, wb_cyc_o}, 32'd0);
        wb_rst = 1'b0;
        sample_ready = 1'b1;
        tick();
        check("rst_mid_rdptr", mem[32'h10C], 32'h1000);

        // start while busy is ignored
        setup(32'h1000, 32'h1008);
        exp_smp_q.push_back(32'hCAFE0001);
        exp_wb_q.push_back({32'h10C, 32'h1004});
        start = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
        start = 1'b1; tick(); start = 1'b0;
        wait_idle(lat);
        repeat (20) tick();
        check("dbl_busy", {31'd0, busy}, 32'd0);
        check("dbl_one_write", n_wr, 32'd1);
        drained("dbl");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
